// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: time-multiplexed column scanner for an LED dot matrix
// Ports: clock (rising edge), reset (asynchronous, active-high), enable (run/stop),
//        frame_data (column c at [c*ROWS +: ROWS]), row_out (1 = lit row of the active column),
//        col_select (one-hot active column, all-zero when dark), frame_start (first cycle of a frame).
// Define MATRIX_SCAN_BLANKING_EN to insert BLANK dark cycles after every column (anti-ghosting).
module matrix_column_scanner #(
    parameter int ROWS  = 7,
    parameter int COLS  = 5,
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] frame_data,
    output logic [ROWS-1:0]      row_out,
    output logic [COLS-1:0]      col_select,
    output logic                 frame_start
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam int PW = $clog2(COLS);
`ifdef MATRIX_SCAN_BLANKING_EN
    localparam int BW = BLANK > 1 ? $clog2(BLANK) : 1;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHOW = 2'd1, S_BLANK = 2'd2} state_t;
    logic [BW-1:0] bcnt, bcnt_n;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHOW = 2'd1} state_t;
`endif
    state_t               state, state_n;
    logic [PW-1:0]        col, col_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [ROWS*COLS-1:0] shadow, shadow_n;
    logic                 load;
    logic                 last_col;
    logic [ROWS-1:0]      row_n;
    logic [COLS-1:0]      sel_n;

    assign last_col = col == PW'(COLS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            col         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            row_out     <= '0;
            col_select  <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            cnt         <= cnt_n;
            shadow      <= shadow_n;
            row_out     <= row_n;
            col_select  <= sel_n;
            frame_start <= load;
        end
    end

`ifdef MATRIX_SCAN_BLANKING_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            bcnt <= '0;
        else
            bcnt <= bcnt_n;
    end
`endif

    // Defaults describe the dark IDLE state, so enable=0 and illegal encodings both land there.
    always_comb begin
        state_n  = S_IDLE;
        col_n    = '0;
        cnt_n    = '0;
        load     = 1'b0;
`ifdef MATRIX_SCAN_BLANKING_EN
        bcnt_n   = '0;
`endif
        if (enable) begin
            case (state)
                S_IDLE: begin
                    state_n = S_SHOW;
                    load    = 1'b1;
                end
                S_SHOW: begin
                    if (cnt == CW'(DWELL - 1)) begin
`ifdef MATRIX_SCAN_BLANKING_EN
                        state_n = S_BLANK;
                        col_n   = col;
`else
                        state_n = S_SHOW;
                        load    = last_col;
                        col_n   = last_col ? '0 : col + PW'(1);
`endif
                    end else begin
                        state_n = S_SHOW;
                        col_n   = col;
                        cnt_n   = cnt + CW'(1);
                    end
                end
`ifdef MATRIX_SCAN_BLANKING_EN
                S_BLANK: begin
                    if (bcnt == BW'(BLANK - 1)) begin
                        state_n = S_SHOW;
                        load    = last_col;
                        col_n   = last_col ? '0 : col + PW'(1);
                    end else begin
                        state_n = S_BLANK;
                        col_n   = col;
                        bcnt_n  = bcnt + BW'(1);
                    end
                end
`endif
                default: state_n = S_IDLE;
            endcase
        end
        shadow_n = load ? frame_data : shadow;
    end

    // Outputs are derived from next-state values so they are registered yet aligned with the state.
    always_comb begin
        row_n = state_n == S_SHOW ? shadow_n[col_n*ROWS +: ROWS] : '0;
        sel_n = state_n == S_SHOW ? COLS'(1) << col_n : '0;
    end
endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner: directed vector bench for matrix_column_scanner (DWELL=4 and DWELL=1 instances)
module tb_matrix_column_scanner;
`ifdef MATRIX_SCAN_BLANKING_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    typedef struct {
        logic        en;
        logic [34:0] fd;
        logic [12:0] exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [34:0] frame_data;
    logic [6:0]  row0, row1;
    logic [4:0]  col0, col1;
    logic        fs0, fs1;
    logic [12:0] o0, o1;
    logic [34:0] fd_a, fd_b;
    vec_t        vq[$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    matrix_column_scanner #(.ROWS(7), .COLS(5), .DWELL(4), .BLANK(2)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .frame_data(frame_data),
        .row_out(row0), .col_select(col0), .frame_start(fs0)
    );

    matrix_column_scanner #(.ROWS(7), .COLS(5), .DWELL(1), .BLANK(2)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .frame_data(frame_data),
        .row_out(row1), .col_select(col1), .frame_start(fs1)
    );

    assign o0 = {row0, col0, fs0};
    assign o1 = {row1, col1, fs1};

    // Expected {row_out, col_select, frame_start} at phase p of a frame for dwell d.
    function automatic logic [12:0] exp_out(input int p, input int d, input logic [34:0] data);
        int         per;
        int         c;
        logic [4:0] sel;
        per = d + BLK;
        c   = p / per;
        if (p % per >= d)
            return '0;
        sel = 5'd1 << c;
        return {data[c*7 +: 7], sel, p == 0};
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got row=%h col=%b fs=%b, expected row=%h col=%b fs=%b",
                     name, act[12:6], act[5:1], act[0], exp[12:6], exp[5:1], exp[0]);
        end
    endtask

    initial begin
        int p1, per4, p4;
        for (int c = 0; c < 5; c++) begin
            fd_a[c*7 +: 7] = 7'(c + 1);
            fd_b[c*7 +: 7] = 7'(c + 'h11);
        end
        reset      = 1'b1;
        enable     = 1'b0;
        frame_data = fd_a;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_u0", o0, '0);
        chk("reset_u1", o1, '0);
        reset  = 1'b0;
        enable = 1'b1;
        p1 = 5 * (1 + BLK);
        for (int t = 0; t < 2 * p1; t++) begin
            @(posedge clock);
            #1;
            chk($sformatf("dwell1_t%0d", t), o1, exp_out(t % p1, 1, fd_a));
        end
        per4 = 4 + BLK;
        p4   = 5 * per4;
        vq.push_back('{1'b0, fd_a, 13'd0});
        for (int t = 0; t < 3 * p4; t++)
            vq.push_back('{1'b1, (t >= p4 + 2 * per4 + 1) ? fd_b : fd_a,
                           exp_out(t % p4, 4, (t < 2 * p4) ? fd_a : fd_b)});
        for (int t = 0; t <= 2 * per4 + 1; t++)
            vq.push_back('{1'b1, fd_b, exp_out(t, 4, fd_b)});
        vq.push_back('{1'b0, fd_b, 13'd0});
        vq.push_back('{1'b0, fd_b, 13'd0});
        for (int t = 0; t <= per4 + 1; t++)
            vq.push_back('{1'b1, fd_b, exp_out(t, 4, fd_b)});
        foreach (vq[i]) begin
            enable     = vq[i].en;
            frame_data = vq[i].fd;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d", i), o0, vq[i].exp);
        end
        @(posedge clock);
        #1;
        chk("pre_reset_u0", o0, exp_out(per4 + 2, 4, fd_b));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_u0", o0, '0);
        chk("async_reset_u1", o1, '0);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("restart_u0", o0, exp_out(0, 4, fd_b));
        chk("restart_u1", o1, exp_out(0, 1, fd_b));
        for (int t = 1; t < 6; t++) begin
            @(posedge clock);
            #1;
            chk($sformatf("after_reset_t%0d", t), o0, exp_out(t, 4, fd_b));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_column_scanner.md
MATRIX_COLUMN_SCANNER -- requirements
Module: matrix_column_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 7: row bits per column.
REQ-002 SHALL have parameter COLS, default 5: columns scanned; legal range is 2 or more.
REQ-003 SHALL have parameter DWELL, default 1000: clock cycles each column is shown; legal range is 1 or more.
REQ-004 SHALL have parameter BLANK, default 2: blanking cycles after each column; used only with the Configuration macro; legal range is 1 or more.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: scan run/stop.
REQ-008 SHALL have port frame_data, input, ROWS*COLS bits: column c occupies bits [c*ROWS +: ROWS].
REQ-009 SHALL have port row_out, output, ROWS bits: row pattern of the active column, 1 = lit.
REQ-010 SHALL have port col_select, output, COLS bits: one-hot active column, all-zero when dark.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse marking the first cycle of a frame.

Function
REQ-012 SHALL register all outputs, with no combinational path from any input to any output.
REQ-013 SHALL implement states IDLE, SHOW and (macro only) BLANK, plus a column pointer col (0..COLS-1) and a dwell counter cnt.
REQ-014 SHALL move IDLE->SHOW on the first edge with enable=1, loading col=0 and cnt=0.
REQ-015 SHALL, on that same IDLE->SHOW edge, copy frame_data into the shadow register, drive col_select=1<<0 and row_out=frame_data column 0, and assert frame_start.
REQ-016 SHALL, in SHOW, drive col_select=1<<col and row_out=shadow column col for exactly DWELL consecutive cycles, with cnt counting 0..DWELL-1.
REQ-017 SHALL, at cnt=DWELL-1 with col<COLS-1, advance col by one and clear cnt (without macro).
REQ-018 SHALL, at cnt=DWELL-1 with col=COLS-1, wrap col to 0, reload the shadow from frame_data and pulse frame_start on the first cycle of column 0.
REQ-019 SHALL keep the displayed data tear-free: frame_data changes mid-frame have no effect until the next frame start.
REQ-020 SHALL make the frame period COLS*DWELL cycles without the macro.
REQ-021 SHALL assert frame_start only in the first cycle of a frame and never otherwise.
REQ-022 SHALL, when enable=0 in any state, go to IDLE on the next edge with col_select=0, row_out=0, frame_start=0 and col, cnt cleared.
REQ-023 SHALL, when enable returns to 1, restart at column 0 with a new frame per REQ-014/REQ-015; there is no mid-frame resume.
REQ-024 SHALL, when DWELL=1, advance the column every cycle.
REQ-025 SHALL size the counter at $clog2(DWELL) bits, minimum 1, so that it never overflows.
REQ-026 SHALL make any illegal state recover to IDLE on the next edge with dark outputs.

Reset
REQ-027 SHALL, on reset asserted, immediately force state=IDLE, col=0, cnt=0, shadow=0, row_out=0, col_select=0 and frame_start=0, independent of clock.
REQ-028 SHALL, when reset asserts mid-frame, abort the frame; after deassertion, scanning follows REQ-014.

Configuration
REQ-029 SHALL use macro MATRIX_SCAN_BLANKING_EN to enable anti-ghosting blanking.
REQ-030 SHALL, with MATRIX_SCAN_BLANKING_EN defined, enter BLANK after each column's DWELL cycles, holding col_select=0 and row_out=0 for BLANK cycles before the next column (or the wrap).
REQ-031 SHALL make the frame period COLS*(DWELL+BLANK) cycles with the macro, with frame_start timing still per REQ-018.
REQ-032 SHALL, with MATRIX_SCAN_BLANKING_EN undefined, exclude the BLANK state, its logic and its counter from the build, making the BLANK parameter unused.

Verification (ROWS=7, COLS=5, DWELL=4, BLANK=2 unless stated)
REQ-033 SHALL cover basic scan: reset, then enable=1 with column c = c+1 -> col_select goes 00001 x4, 00010 x4, ... 10000 x4, then repeats; row_out shows 1..5; frame_start is high every 20 cycles.
REQ-034 SHALL cover tear-free update: frame_data changes during column 2 -> columns 2..4 still show old data; new data appears only after the next frame_start.
REQ-035 SHALL cover enable drop: enable=0 during column 2, cycle 1 -> next cycle all outputs are 0; enable=1 -> frame_start is high with col_select=00001 on the same edge.
REQ-036 SHALL cover async reset: reset pulse between clock edges mid-frame -> outputs are 0 before the next edge; scanning restarts per REQ-014.
REQ-037 SHALL cover blanking: with macro, 2 all-zero cycles follow every 4-cycle column and the frame period is 30 cycles; without macro, there are no dark cycles while enable=1.
REQ-038 SHALL cover the DWELL boundary: DWELL=1 -> col_select rotates every cycle and frame_start is high every 5 cycles.
